// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared constants and helpers for the data-memory arbiter.
//   PORT_CPU / PORT_DBG : requester indices (bit positions in req/gnt/rvalid)
//   PRIO_RR / PRIO_FIXED: PRIORITY_MODE encodings
//   WAIT_CNT_W          : width of the port-1 starvation counter
package dmem_arbiter_pkg;

    localparam int unsigned NUM_PORTS  = 2;

    localparam int unsigned PORT_CPU   = 0;
    localparam int unsigned PORT_DBG   = 1;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

    localparam int unsigned WAIT_CNT_W = 4;

    // Index of the granted port for a one-hot-or-zero grant. An idle grant maps to
    // port 0 so the memory-side muxes default to the CPU fields.
    function automatic logic gnt_idx(input logic [NUM_PORTS-1:0] gnt);
        return gnt[PORT_DBG];
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the requester handshake and the BRAM bus.
//   req/we/mode/addr/wdata : per-port request fields, {port1, port0}
//   gnt/rvalid/rdata       : per-port grant, read-data valid, shared read data
//   mem_*                  : single-port BRAM bus (one-cycle registered read)
// Modports:
//   slave  : the arbiter view
//   master : the environment view (requesters plus the BRAM read port)
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);

    logic [1:0]              req;
    logic [1:0]              we;
    logic [3:0]              mode;
    logic [2*ADDR_WIDTH-1:0] addr;
    logic [2*DATA_WIDTH-1:0] wdata;

    logic [1:0]              gnt;
    logic [1:0]              rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [1:0]              mem_mode;
    logic                    mem_wr_en;
    logic                    mem_rd_en;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport slave (
        input  req, we, mode, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_mode, mem_wr_en, mem_rd_en
    );

    modport master (
        output req, we, mode, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_mode, mem_wr_en, mem_rd_en
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-requester grant decode with last-grant pointer and starvation guard.
//   sysclk : clock, all state on rising edge
//   rst    : synchronous reset, active-low; also forces gnt=00 while low
//   req    : per-port request
//   gnt    : one-hot-or-zero grant, combinational
// PRIORITY_MODE=PRIO_RR alternates on contention; PRIO_FIXED favours port 0 but hands
// port 1 the grant once it has lost MAX_WAIT consecutive cycles.
module rr_arbiter_2
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned PRIORITY_MODE = PRIO_RR,
    parameter int unsigned MAX_WAIT      = 4
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam logic [WAIT_CNT_W-1:0] WaitMax = WAIT_CNT_W'(MAX_WAIT);
    localparam logic [WAIT_CNT_W-1:0] WaitOne = WAIT_CNT_W'(1);

    logic                  last_gnt_q, last_gnt_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Grant decode
    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            case (req)
                2'b01: gnt = 2'b01;
                2'b10: gnt = 2'b10;
                2'b11: begin
                    if (PRIORITY_MODE == PRIO_FIXED) begin
                        gnt = (wait_cnt_q == WaitMax) ? 2'b10 : 2'b01;
                    end else begin
                        // Hand the contest to the port that did not win last time
                        gnt = last_gnt_q ? 2'b01 : 2'b10;
                    end
                end
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer and starvation counter next state
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt != 2'b00) begin
            last_gnt_d = gnt[PORT_DBG];
        end

        wait_cnt_d = '0;
        if ((PRIORITY_MODE == PRIO_FIXED) && req[PORT_DBG] && !gnt[PORT_DBG]) begin
            wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + WaitOne;
        end
    end

    // last_gnt resets to port 1 so port 0 wins the first contest
    always_ff @(posedge sysclk) begin
        if (!rst) begin
            last_gnt_q <= 1'b1;
            wait_cnt_q <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory BRAM between the CPU (port 0) and a
// debug/loader master (port 1). At most one access is granted per cycle; read
// data returns one cycle later tagged with a per-port rvalid.
//   sysclk : clock, all state on rising edge
//   rst    : synchronous reset, active-low
//   bus    : dmem_arbiter_if.slave, requester handshake plus BRAM bus
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned PRIORITY_MODE = PRIO_RR,
    parameter int unsigned MAX_WAIT      = 4
) (
    input  logic           sysclk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    logic [1:0] gnt;
    logic       sel;
    logic       granted;
    logic       sel_we;
    logic [1:0] rvalid_d, rvalid_q;

    rr_arbiter_2 #(
        .PRIORITY_MODE (PRIORITY_MODE),
        .MAX_WAIT      (MAX_WAIT)
    ) u_arb (
        .sysclk (sysclk),
        .rst    (rst),
        .req    (bus.req),
        .gnt    (gnt)
    );

    assign sel     = gnt_idx(gnt);
    assign granted = |gnt;
    assign sel_we  = bus.we[sel];

    // Memory-side muxes; port 0 fields pass through when nothing is granted
    always_comb begin
        bus.mem_addr  = bus.addr[ADDR_WIDTH-1:0];
        bus.mem_wdata = bus.wdata[DATA_WIDTH-1:0];
        bus.mem_mode  = bus.mode[1:0];
        if (sel) begin
            bus.mem_addr  = bus.addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
            bus.mem_wdata = bus.wdata[2*DATA_WIDTH-1:DATA_WIDTH];
            bus.mem_mode  = bus.mode[3:2];
        end
    end

    assign bus.mem_wr_en = granted & sel_we;
    assign bus.mem_rd_en = granted & ~sel_we;

    // A granted read on port i returns on rvalid[i] one cycle later
    assign rvalid_d = gnt & ~bus.we;

    always_ff @(posedge sysclk) begin
        if (!rst) begin
            rvalid_q <= 2'b00;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    // Masked while rst is low so a read granted just before reset never returns
    assign bus.rvalid = rst ? rvalid_q : 2'b00;
    assign bus.rdata  = bus.mem_rdata;
    assign bus.gnt    = gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a read-data scoreboard. Two instances:
// round-robin (driven through a BRAM model) and fixed priority with MAX_WAIT=4.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    localparam logic [DW-1:0] DAT_A = 32'hA0A0_0004;
    localparam logic [DW-1:0] DAT_B = 32'hB0B0_0008;
    localparam logic [DW-1:0] DAT_C = 32'hC0DE_0004;
    localparam logic [DW-1:0] DAT_D = 32'hDEAD_BEEF;
    localparam logic [DW-1:0] DAT_W = 32'h1234_5678;

    logic sysclk = 1'b0;
    logic rst    = 1'b0;
    always #5 sysclk = ~sysclk;

    dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_rr ();
    dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_fx ();

    dmem_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .PRIORITY_MODE (PRIO_RR),
        .MAX_WAIT      (4)
    ) u_dut_rr (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus_rr)
    );

    dmem_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .PRIORITY_MODE (PRIO_FIXED),
        .MAX_WAIT      (4)
    ) u_dut_fx (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus_fx)
    );

    // BRAM model: registered read returns pre-write contents
    logic [DW-1:0] mem [4096];
    always @(posedge sysclk) begin
        if (bus_rr.mem_wr_en) mem[bus_rr.mem_addr] <= bus_rr.mem_wdata;
        if (bus_rr.mem_rd_en) bus_rr.mem_rdata <= mem[bus_rr.mem_addr];
    end
    assign bus_fx.mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]    port;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic set_rr(input logic [1:0] req, input logic [1:0] we, input logic [3:0] mode,
                          input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                          input logic [DW-1:0] w1, input logic [DW-1:0] w0);
        bus_rr.req   = req;
        bus_rr.we    = we;
        bus_rr.mode  = mode;
        bus_rr.addr  = {a1, a0};
        bus_rr.wdata = {w1, w0};
    endtask

    task automatic push(input logic [1:0] port, input logic [DW-1:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic chk_bus(input string tag, input logic [1:0] gnt, input logic wr,
                           input logic rd);
        check({tag, "_gnt"}, 64'(bus_rr.gnt), 64'(gnt));
        check({tag, "_wr_en"}, 64'(bus_rr.mem_wr_en), 64'(wr));
        check({tag, "_rd_en"}, 64'(bus_rr.mem_rd_en), 64'(rd));
    endtask

    // Monitor: pops the scoreboard on every rvalid and checks the invariants
    initial begin
        exp_t e;
        forever begin
            @(negedge sysclk);
            check("gnt_not_11", 64'(bus_rr.gnt == 2'b11), 64'(0));
            check("wr_rd_excl", 64'(bus_rr.mem_wr_en & bus_rr.mem_rd_en), 64'(0));
            if (bus_rr.rvalid !== 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", 64'(bus_rr.rvalid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("rvalid_port", 64'(bus_rr.rvalid), 64'(e.port));
                    check("rdata", 64'(bus_rr.rdata), 64'(e.data));
                end
            end
        end
    end

    initial begin
        set_rr(2'b11, 2'b00, 4'b0000, 12'h008, 12'h004, '0, '0);
        bus_fx.req   = 2'b11;
        bus_fx.we    = 2'b11;
        bus_fx.mode  = '0;
        bus_fx.addr  = '0;
        bus_fx.wdata = '0;

        // Reset held for three edges with both ports requesting
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            chk_bus("rst", 2'b00, 1'b0, 1'b0);
            check("rst_rvalid", 64'(bus_rr.rvalid), 64'(0));
            check("rst_fx_gnt", 64'(bus_fx.gnt), 64'(0));
        end

        // Release: both write, port 0 wins the first contest
        tick();
        rst        = 1'b1;
        bus_fx.req = 2'b00;
        set_rr(2'b11, 2'b11, 4'b0000, 12'h008, 12'h004, DAT_B, DAT_A);
        @(negedge sysclk);
        chk_bus("first", 2'b01, 1'b1, 1'b0);
        check("first_addr", 64'(bus_rr.mem_addr), 64'(12'h004));
        check("first_wdata", 64'(bus_rr.mem_wdata), 64'(DAT_A));

        tick();
        set_rr(2'b10, 2'b11, 4'b0000, 12'h008, 12'h004, DAT_B, DAT_A);
        @(negedge sysclk);
        chk_bus("p1_wr", 2'b10, 1'b1, 1'b0);
        check("p1_wr_addr", 64'(bus_rr.mem_addr), 64'(12'h008));
        check("p1_wr_wdata", 64'(bus_rr.mem_wdata), 64'(DAT_B));

        // Single-port write then read
        tick();
        set_rr(2'b01, 2'b01, 4'b0000, 12'h000, 12'h010, '0, DAT_D);
        @(negedge sysclk);
        chk_bus("p0_wr", 2'b01, 1'b1, 1'b0);

        tick();
        set_rr(2'b01, 2'b00, 4'b0000, 12'h000, 12'h010, '0, '0);
        push(2'b01, DAT_D);
        @(negedge sysclk);
        chk_bus("p0_rd", 2'b01, 1'b0, 1'b1);
        check("p0_rd_addr", 64'(bus_rr.mem_addr), 64'(12'h010));

        // Port 1 read, concurrent with the port 0 return
        tick();
        set_rr(2'b10, 2'b00, 4'b0000, 12'h008, 12'h004, '0, '0);
        push(2'b10, DAT_B);
        @(negedge sysclk);
        chk_bus("p1_rd", 2'b10, 1'b0, 1'b1);

        // Round-robin contention
        for (int k = 0; k < 6; k++) begin
            tick();
            set_rr(2'b11, 2'b00, 4'b0000, 12'h008, 12'h004, '0, '0);
            if (k % 2 == 0) push(2'b01, DAT_A);
            else push(2'b10, DAT_B);
            @(negedge sysclk);
            chk_bus("rr", (k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b1);
        end

        // Write isolation on port 1 with a non-zero mode
        tick();
        set_rr(2'b10, 2'b10, 4'b1000, 12'h020, 12'h000, DAT_W, '0);
        @(negedge sysclk);
        chk_bus("iso_wr", 2'b10, 1'b1, 1'b0);
        check("iso_mode", 64'(bus_rr.mem_mode), 64'(2'b10));
        check("iso_addr", 64'(bus_rr.mem_addr), 64'(12'h020));
        check("iso_wdata", 64'(bus_rr.mem_wdata), 64'(DAT_W));

        tick();
        set_rr(2'b01, 2'b00, 4'b0000, 12'h000, 12'h020, '0, '0);
        push(2'b01, DAT_W);
        @(negedge sysclk);
        chk_bus("iso_rd", 2'b01, 1'b0, 1'b1);
        check("iso_no_rvalid", 64'(bus_rr.rvalid), 64'(0));

        // Read followed by a write to the same address returns old data
        tick();
        set_rr(2'b01, 2'b00, 4'b0000, 12'h000, 12'h004, '0, '0);
        push(2'b01, DAT_A);
        @(negedge sysclk);
        chk_bus("raw_rd", 2'b01, 1'b0, 1'b1);

        tick();
        set_rr(2'b10, 2'b10, 4'b0000, 12'h004, 12'h000, DAT_C, '0);
        @(negedge sysclk);
        chk_bus("raw_wr", 2'b10, 1'b1, 1'b0);

        tick();
        set_rr(2'b01, 2'b00, 4'b0000, 12'h000, 12'h004, '0, '0);
        push(2'b01, DAT_C);
        @(negedge sysclk);
        chk_bus("raw_rd2", 2'b01, 1'b0, 1'b1);

        // Reset immediately after a granted port 1 read: no return
        tick();
        set_rr(2'b10, 2'b00, 4'b0000, 12'h008, 12'h000, '0, '0);
        @(negedge sysclk);
        chk_bus("mid_rd", 2'b10, 1'b0, 1'b1);

        for (int i = 0; i < 2; i++) begin
            tick();
            rst = 1'b0;
            set_rr(2'b11, 2'b00, 4'b0000, 12'h008, 12'h010, '0, '0);
            @(negedge sysclk);
            chk_bus("mid_rst", 2'b00, 1'b0, 1'b0);
            check("mid_rst_rvalid", 64'(bus_rr.rvalid), 64'(0));
        end

        tick();
        rst = 1'b1;
        push(2'b01, DAT_D);
        @(negedge sysclk);
        chk_bus("post_rst", 2'b01, 1'b0, 1'b1);

        tick();
        set_rr(2'b10, 2'b00, 4'b0000, 12'h008, 12'h010, '0, '0);
        push(2'b10, DAT_B);
        @(negedge sysclk);
        chk_bus("post_rst_p1", 2'b10, 1'b0, 1'b1);

        tick();
        set_rr(2'b00, 2'b00, 4'b0000, 12'h000, 12'h000, '0, '0);
        @(negedge sysclk);
        chk_bus("idle", 2'b00, 1'b0, 1'b0);

        // Fixed priority with starvation guard: 01 x4, 10, 01 x4, 10
        for (int k = 0; k < 10; k++) begin
            tick();
            bus_fx.req = 2'b11;
            bus_fx.we  = 2'b11;
            @(negedge sysclk);
            check("fx_gnt", 64'(bus_fx.gnt), (k == 4 || k == 9) ? 64'(2'b10) : 64'(2'b01));
            check("fx_wr_en", 64'(bus_fx.mem_wr_en), 64'(1));
            check("fx_rvalid", 64'(bus_fx.rvalid), 64'(0));
        end

        tick();
        bus_fx.req = 2'b00;
        tick();
        @(negedge sysclk);
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
